mem_indirect_sequencer: RTL and testbench
=========================================

// Module: mem_indirect_sequencer
// PURPOSE
//  MEM-stage sequencer for LC-3b data accesses. It sits between the EX/MEM register, the dcache and MEM/WB.
//  LDR/STR take one dcache access. LDI/STI take two: a pointer read at the EA, then a load/store at the pointer.
//  It freezes the upstream pipeline while busy.
//  Optionally it acts as the producer of the EX/MEM->ID/EX replay packet: LDI/STI phase 2 is re-injected upstream as LDR/STR.
// PARAMETERS
//  DATA_W    16   word / address width
//  MAX_WAIT  255  dcache watchdog, in cycles; 0 disables the watchdog
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  mem_valid_in   in   1       EX/MEM holds a valid instruction
//  opcode_in      in   4       lc3b_opcode of the EX/MEM instruction
//  ea_in          in   16      effective address from EX
//  store_data_in  in   16      SR value for STR/STI
//  dest_in        in   3       destination register
//  dcache_read    out  1       dcache read strobe
//  dcache_write   out  1       dcache write strobe
//  dcache_addr    out  16      dcache address; bit0 forced to 0
//  dcache_wdata   out  16      write data
//  dcache_wmask   out  2       2'b11 on writes, 2'b00 otherwise
//  dcache_rdata   in   16      read data
//  dcache_resp    in   1       one-cycle completion pulse
//  stall_out      out  1       freeze IF/ID, ID/EX and EX/MEM
//  wb_valid       out  1       one-cycle pulse: access complete
//  wb_data        out  16      loaded word; 0 for stores
//  wb_dest        out  3       dest for the writeback
//  mem_err        out  1       pulse with wb_valid on watchdog expiry
//  replay_valid   out  1       replay packet valid (REPLAY build only)
//  replay_opcode  out  4       op_ldr / op_str
//  replay_dest    out  3       original dest
//  replay_sr1     out  16      pointer value, fed as base with offset 0
// BEHAVIOUR
//  States: IDLE, PTR, ACC_RD, ACC_WR, DONE.
//  Reset (async): state=IDLE. All outputs 0 immediately; ptr_q, data_q and wait_cnt are cleared.
//  IDLE:
//   - mem_valid_in & (op_ldi|op_sti) -> PTR.
//   - op_ldr -> ACC_RD with addr=ea_in.
//   - op_str -> ACC_WR with addr=ea_in.
//   - Any other opcode: stay in IDLE, no stall.
//   - stall_out is asserted combinationally in the accept cycle.
//  PTR: dcache_read=1, addr=ea_q. On resp: ptr_q <= {rdata[15:1],1'b0}; LDI -> ACC_RD, STI -> ACC_WR.
//  ACC_RD: read at addr_q. On resp: data_q <= rdata -> DONE.
//  ACC_WR: write store_q at addr_q, wmask 2'b11. On resp -> DONE.
//  DONE:
//   - stall_out=0; wb_valid=1 for exactly one cycle; wb_dest=dest_q.
//   - wb_data=data_q for loads, 0 for stores.
//   - Next state: IDLE.
//  stall_out=1 in PTR, ACC_RD and ACC_WR. EA, store data and dest are latched at accept, so input changes while busy are ignored.
//  Strobes stay high until the cycle dcache_resp=1. They drop in the cycle after resp.
//  dcache_resp outside PTR/ACC_* is ignored.
//  Watchdog:
//   - wait_cnt clears on each state entry and counts cycles without resp.
//   - When wait_cnt==MAX_WAIT (MAX_WAIT!=0): go to DONE with mem_err=1, wb_data=0, strobes dropped.
//  Pointer value 0x0000 is legal. Address arithmetic has no wrap checks.
//  Latency with a 1-cycle resp: LDR/STR reach DONE 2 cycles after accept; LDI/STI reach DONE 3 cycles after accept.
//  Reset mid-access: the access is abandoned and no wb_valid is issued.
// CONFIGURATION
//  MEM_INDIRECT_REPLAY_EN defined:
//   - When PTR gets resp, go to DONE with wb_valid=0.
//   - In that DONE cycle: replay_valid=1 for one cycle, replay_opcode=op_ldr (LDI) or op_str (STI), replay_sr1=ptr_q, replay_dest=dest_q.
//   - ID/EX re-issues phase 2 as an ordinary LDR/STR. While that re-issued LDR/STR is being accepted, replay_valid is never asserted.
//  Undefined: the replay ports are tied to 0 and phase 2 runs internally as above.
// TESTING
//  1. LDR ea=0x1002, resp after 1 cycle, rdata=0xBEEF -> one read at 0x1002; wb_valid with wb_data=0xBEEF, dest=R3; stall_out for 2 cycles.
//  2. LDI ea=0x2000; mem[0x2000]=0x3001, mem[0x3000]=0x1234 -> reads at 0x2000 then 0x3000; wb_data=0x1234; no writes issued.
//  3. STI ea=0x2000, ptr=0x4000, SR=0xA5A5 -> read at 0x2000, then write 0xA5A5 at 0x4000 with wmask=11; wb_data=0.
//  4. resp held off 5 cycles in PTR; change ea_in mid-wait -> strobe stays high at the original address; result is correct.
//  5. MAX_WAIT=4, resp never comes -> DONE after 4 wait cycles, mem_err=1 and wb_valid=1 together; back to IDLE.
//  6. rst_n low during ACC_RD -> strobes and stall low immediately; no wb_valid; with REPLAY_EN, an LDI gives replay_valid, op_ldr, sr1=ptr.

Source files
------------

// File: rtl/mem_indirect_sequencer.sv
// LC-3b MEM-stage sequencer: one dcache access for LDR/STR, pointer fetch plus access for LDI/STI.
// Optional MEM_INDIRECT_REPLAY_EN hands LDI/STI phase 2 back upstream as an LDR/STR replay packet.
module mem_indirect_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_in,
    input  logic [3:0]        opcode_in,
    input  logic [DATA_W-1:0] ea_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [2:0]        dest_in,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [DATA_W-1:0] dcache_addr,
    output logic [DATA_W-1:0] dcache_wdata,
    output logic [1:0]        dcache_wmask,
    input  logic [DATA_W-1:0] dcache_rdata,
    input  logic              dcache_resp,
    output logic              stall_out,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        wb_dest,
    output logic              mem_err,
    output logic              replay_valid,
    output logic [3:0]        replay_opcode,
    output logic [2:0]        replay_dest,
    output logic [DATA_W-1:0] replay_sr1
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [DATA_W-1:0] ADDR_MASK = {{(DATA_W-1){1'b1}}, 1'b0};
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PTR    = 3'd1,
        S_ACC_RD = 3'd2,
        S_ACC_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_read;
    logic                r_write;
    logic [1:0]          r_wmask;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_dest_q;
    logic                r_is_load;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_data;
    logic [2:0]          r_wb_dest;
    logic                r_mem_err;

    logic                w_is_ldr;
    logic                w_is_str;
    logic                w_is_ldi;
    logic                w_is_sti;
    logic                w_accept;
    logic                w_busy;
    logic [WAIT_W-1:0]   w_wait_next;
    logic                w_timeout;

    assign w_is_ldr    = (opcode_in == OP_LDR);
    assign w_is_str    = (opcode_in == OP_STR);
    assign w_is_ldi    = (opcode_in == OP_LDI);
    assign w_is_sti    = (opcode_in == OP_STI);
    // Reset gates the accept term so stall_out is low while rst_n is asserted.
    assign w_accept    = rst_n & (r_state == S_IDLE) & mem_valid_in
                         & (w_is_ldr | w_is_str | w_is_ldi | w_is_sti);
    assign w_busy      = (r_state == S_PTR) | (r_state == S_ACC_RD) | (r_state == S_ACC_WR);
    assign w_wait_next = r_wait_cnt + WAIT_W'(1);
    assign w_timeout   = (MAX_WAIT != 0) && (w_wait_next == WAIT_W'(MAX_WAIT));

`ifdef MEM_INDIRECT_REPLAY_EN
    logic                r_replay_valid;
    logic [3:0]          r_replay_opcode;
    logic [2:0]          r_replay_dest;
    logic [DATA_W-1:0]   r_replay_sr1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_wmask    <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dest_q   <= '0;
            r_is_load  <= 1'b0;
            r_wait_cnt <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_dest  <= '0;
            r_mem_err  <= 1'b0;
`ifdef MEM_INDIRECT_REPLAY_EN
            r_replay_valid  <= 1'b0;
            r_replay_opcode <= '0;
            r_replay_dest   <= '0;
            r_replay_sr1    <= '0;
`endif
        end else begin
            // Writeback and replay fields are one-cycle pulses.
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_dest  <= '0;
            r_mem_err  <= 1'b0;
`ifdef MEM_INDIRECT_REPLAY_EN
            r_replay_valid  <= 1'b0;
            r_replay_opcode <= '0;
            r_replay_dest   <= '0;
            r_replay_sr1    <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dest_q   <= dest_in;
                        r_is_load  <= w_is_ldr | w_is_ldi;
                        r_wait_cnt <= '0;
                        r_addr     <= ea_in & ADDR_MASK;
                        r_wdata    <= store_data_in;
                        if (w_is_ldi | w_is_sti) begin
                            r_state <= S_PTR;
                            r_read  <= 1'b1;
                        end else if (w_is_ldr) begin
                            r_state <= S_ACC_RD;
                            r_read  <= 1'b1;
                        end else begin
                            r_state <= S_ACC_WR;
                            r_write <= 1'b1;
                            r_wmask <= 2'b11;
                        end
                    end
                end

                S_PTR, S_ACC_RD, S_ACC_WR: begin
                    if (dcache_resp) begin
                        r_wait_cnt <= '0;
                        if (r_state == S_PTR) begin
`ifdef MEM_INDIRECT_REPLAY_EN
                            r_read          <= 1'b0;
                            r_state         <= S_DONE;
                            r_replay_valid  <= 1'b1;
                            r_replay_opcode <= r_is_load ? OP_LDR : OP_STR;
                            r_replay_dest   <= r_dest_q;
                            r_replay_sr1    <= dcache_rdata & ADDR_MASK;
`else
                            r_addr <= dcache_rdata & ADDR_MASK;
                            if (r_is_load) begin
                                r_state <= S_ACC_RD;
                            end else begin
                                r_read  <= 1'b0;
                                r_write <= 1'b1;
                                r_wmask <= 2'b11;
                                r_state <= S_ACC_WR;
                            end
`endif
                        end else if (r_state == S_ACC_RD) begin
                            r_read     <= 1'b0;
                            r_state    <= S_DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= dcache_rdata;
                            r_wb_dest  <= r_dest_q;
                        end else begin
                            r_write    <= 1'b0;
                            r_wmask    <= 2'b00;
                            r_state    <= S_DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_dest  <= r_dest_q;
                        end
                    end else if (w_timeout) begin
                        // Watchdog: abandon the access and report it with the writeback pulse.
                        r_read     <= 1'b0;
                        r_write    <= 1'b0;
                        r_wmask    <= 2'b00;
                        r_wait_cnt <= '0;
                        r_state    <= S_DONE;
                        r_wb_valid <= 1'b1;
                        r_wb_dest  <= r_dest_q;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dcache_read  = r_read;
    assign dcache_write = r_write;
    assign dcache_addr  = r_addr;
    assign dcache_wdata = r_wdata;
    assign dcache_wmask = r_wmask;
    assign stall_out    = w_busy | w_accept;
    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;
    assign wb_dest      = r_wb_dest;
    assign mem_err      = r_mem_err;

`ifdef MEM_INDIRECT_REPLAY_EN
    assign replay_valid  = r_replay_valid;
    assign replay_opcode = r_replay_opcode;
    assign replay_dest   = r_replay_dest;
    assign replay_sr1    = r_replay_sr1;
`else
    assign replay_valid  = 1'b0;
    assign replay_opcode = 4'b0000;
    assign replay_dest   = 3'b000;
    assign replay_sr1    = '0;
`endif

endmodule

// File: tb/tb_mem_indirect_sequencer.sv
// Bench for mem_indirect_sequencer (default build): memory responder with programmable latency,
// per-instruction reference model of accesses, latency, stall and writeback.
module tb_mem_indirect_sequencer;

    localparam int unsigned MAXW = 4;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic [3:0]  opcode_in = 4'b0;
    logic [15:0] ea_in = 16'h0;
    logic [15:0] store_data_in = 16'h0;
    logic [2:0]  dest_in = 3'b0;
    logic        dcache_read, dcache_write;
    logic [15:0] dcache_addr, dcache_wdata;
    logic [1:0]  dcache_wmask;
    logic [15:0] dcache_rdata = 16'h0;
    logic        dcache_resp = 1'b0;
    logic        stall_out, wb_valid, mem_err;
    logic [15:0] wb_data;
    logic [2:0]  wb_dest;
    logic        replay_valid;
    logic [3:0]  replay_opcode;
    logic [2:0]  replay_dest;
    logic [15:0] replay_sr1;

    int n_checks = 0;
    int n_errors = 0;
    int lat_cfg = 0;
    int viol = 0;
    bit spur_en = 1'b1;

    logic [15:0] mem [logic [15:0]];
    bit          tr_we[$];
    logic [15:0] tr_addr[$];
    logic [15:0] tr_wd[$];
    bit          rsp_busy = 1'b0;
    int          rsp_cnt = 0;
    logic [15:0] rsp_addr = 16'h0;

    mem_indirect_sequencer #(.DATA_W(16), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_in(mem_valid_in), .opcode_in(opcode_in), .ea_in(ea_in),
        .store_data_in(store_data_in), .dest_in(dest_in),
        .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_wmask(dcache_wmask),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .stall_out(stall_out), .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
        .mem_err(mem_err), .replay_valid(replay_valid), .replay_opcode(replay_opcode),
        .replay_dest(replay_dest), .replay_sr1(replay_sr1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mrd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hC3A5;
    endfunction

    // dcache responder: resp after lat_cfg stalled cycles; random resp noise when no strobe is up.
    always @(negedge clk) begin
        if (dcache_read || dcache_write) begin
            if (!rsp_busy) begin
                rsp_busy = 1'b1;
                rsp_cnt  = 0;
                rsp_addr = dcache_addr;
            end else if (dcache_addr !== rsp_addr) begin
                viol++;
            end
            if (dcache_read && dcache_write) viol++;
            if (dcache_wmask !== (dcache_write ? 2'b11 : 2'b00)) viol++;
            if (rsp_cnt == lat_cfg) begin
                dcache_resp  = 1'b1;
                dcache_rdata = dcache_read ? mrd(dcache_addr) : 16'($urandom);
                if (dcache_write) mem[dcache_addr] = dcache_wdata;
                tr_we.push_back(dcache_write);
                tr_addr.push_back(dcache_addr);
                tr_wd.push_back(dcache_write ? dcache_wdata : 16'h0);
                rsp_busy = 1'b0;
            end else begin
                dcache_resp  = 1'b0;
                dcache_rdata = 16'($urandom);
                rsp_cnt++;
            end
        end else begin
            rsp_busy     = 1'b0;
            dcache_resp  = spur_en ? 1'($urandom) : 1'b0;
            dcache_rdata = 16'($urandom);
            if (dcache_wmask !== 2'b00) viol++;
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] ea,
                          input logic [15:0] sd, input logic [2:0] dest, input int lat,
                          output logic [15:0] obs_data);
        logic [15:0] a0, a1, exp_data;
        logic [2:0]  obs_dest;
        int          exp_cyc, stalls, cyc;
        bit          exp_err, got, obs_err, stall_done, ind, ld;
        bit          e_we[$];
        logic [15:0] e_addr[$];
        logic [15:0] e_wd[$];

        ind = (op == OP_LDI) || (op == OP_STI);
        ld  = (op == OP_LDR) || (op == OP_LDI);
        exp_cyc = 0; exp_err = 1'b0; exp_data = 16'h0;
        a0 = ea & 16'hFFFE;
        a1 = a0;
        if (ind) begin
            if (lat >= int'(MAXW)) begin
                exp_cyc += int'(MAXW); exp_err = 1'b1;
            end else begin
                exp_cyc += lat + 1;
                e_we.push_back(1'b0); e_addr.push_back(a0); e_wd.push_back(16'h0);
                a1 = mrd(a0) & 16'hFFFE;
            end
        end
        if (!exp_err) begin
            if (lat >= int'(MAXW)) begin
                exp_cyc += int'(MAXW); exp_err = 1'b1;
            end else begin
                exp_cyc += lat + 1;
                e_we.push_back(!ld); e_addr.push_back(a1); e_wd.push_back(ld ? 16'h0 : sd);
                if (ld) exp_data = mrd(a1);
            end
        end

        tr_we.delete(); tr_addr.delete(); tr_wd.delete();
        viol = 0;
        lat_cfg = lat;
        obs_data = 16'h0; obs_dest = 3'h0; obs_err = 1'b0; stall_done = 1'b0; got = 1'b0;
        @(negedge clk);
        mem_valid_in = 1'b1; opcode_in = op; ea_in = ea; store_data_in = sd; dest_in = dest;
        #1;
        stalls = stall_out ? 1 : 0;
        cyc = 0;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (wb_valid) begin
                got = 1'b1;
                obs_data = wb_data; obs_dest = wb_dest; obs_err = mem_err; stall_done = stall_out;
                mem_valid_in = 1'b0;
            end else begin
                if (stall_out) stalls++;
                opcode_in = 4'($urandom); ea_in = 16'($urandom);
                store_data_in = 16'($urandom); dest_in = 3'($urandom);
            end
        end
        mem_valid_in = 1'b0;

        n_checks++;
        if (!got) begin n_errors++; $display("FAIL %s: wb_valid never seen within %0d cycles", name, cyc); end
        n_checks++;
        if (cyc != exp_cyc + 1) begin n_errors++; $display("FAIL %s: latency got %0d exp %0d", name, cyc, exp_cyc + 1); end
        n_checks++;
        if (stalls != exp_cyc + 1 || stall_done) begin
            n_errors++; $display("FAIL %s: stall cycles got %0d (in DONE %0b) exp %0d", name, stalls, stall_done, exp_cyc + 1);
        end
        n_checks++;
        if (obs_data !== exp_data || obs_dest !== dest || obs_err !== exp_err) begin
            n_errors++;
            $display("FAIL %s: wb data/dest/err got %h/%0d/%0b exp %h/%0d/%0b", name, obs_data, obs_dest, obs_err, exp_data, dest, exp_err);
        end
        n_checks++;
        if (tr_we.size() != e_we.size()) begin
            n_errors++; $display("FAIL %s: access count got %0d exp %0d", name, tr_we.size(), e_we.size());
        end else begin
            for (int i = 0; i < e_we.size(); i++) begin
                if (tr_we[i] !== e_we[i] || tr_addr[i] !== e_addr[i] || tr_wd[i] !== e_wd[i]) begin
                    n_errors++;
                    $display("FAIL %s: access %0d got we=%0b a=%h d=%h exp we=%0b a=%h d=%h", name, i, tr_we[i], tr_addr[i], tr_wd[i], e_we[i], e_addr[i], e_wd[i]);
                    break;
                end
            end
        end
        n_checks++;
        if (viol != 0) begin n_errors++; $display("FAIL %s: strobe protocol violations got %0d exp 0", name, viol); end
        @(posedge clk); #1;
        n_checks++;
        if (wb_valid || stall_out || dcache_read || dcache_write) begin
            n_errors++; $display("FAIL %s: not idle after DONE wb=%0b stall=%0b rd=%0b wr=%0b", name, wb_valid, stall_out, dcache_read, dcache_write);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_valid_in = 1'b1; opcode_in = OP_LDI; ea_in = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({dcache_read, dcache_write, dcache_wmask, stall_out, wb_valid, mem_err, replay_valid} !== 8'h0
            || dcache_addr !== 16'h0 || wb_data !== 16'h0) begin
            n_errors++;
            $display("FAIL reset: rd=%0b wr=%0b mask=%b stall=%0b wb=%0b err=%0b addr=%h wbd=%h exp all 0",
                     dcache_read, dcache_write, dcache_wmask, stall_out, wb_valid, mem_err, dcache_addr, wb_data);
        end
        @(negedge clk);
        mem_valid_in = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] d;
        mem[16'h1002] = 16'hBEEF;
        mem[16'h2000] = 16'h3001;
        mem[16'h3000] = 16'h1234;
        run_op("ldr_basic", OP_LDR, 16'h1002, 16'h0, 3'd3, 0, d);
        n_checks++;
        if (d !== 16'hBEEF) begin n_errors++; $display("FAIL ldr_basic: data got %h exp beef", d); end
        run_op("ldi_basic", OP_LDI, 16'h2000, 16'h0, 3'd5, 0, d);
        n_checks++;
        if (d !== 16'h1234) begin n_errors++; $display("FAIL ldi_basic: data got %h exp 1234", d); end
        mem[16'h2000] = 16'h4000;
        run_op("sti_basic", OP_STI, 16'h2000, 16'hA5A5, 3'd1, 0, d);
        n_checks++;
        if (d !== 16'h0 || mrd(16'h4000) !== 16'hA5A5) begin
            n_errors++; $display("FAIL sti_basic: data %h mem[4000] %h exp 0000/a5a5", d, mrd(16'h4000));
        end
    endtask

    task automatic test_hold_off();
        logic [15:0] d;
        mem[16'h2400] = 16'h2601;
        mem[16'h2600] = 16'h7777;
        run_op("ldi_hold", OP_LDI, 16'h2401, 16'h0, 3'd6, int'(MAXW) - 1, d);
        n_checks++;
        if (d !== 16'h7777) begin n_errors++; $display("FAIL ldi_hold: data got %h exp 7777", d); end
        run_op("str_hold", OP_STR, 16'h2801, 16'h5AA5, 3'd7, 2, d);
    endtask

    task automatic test_watchdog();
        logic [15:0] d;
        run_op("ldr_timeout", OP_LDR, 16'h0300, 16'h0, 3'd2, 255, d);
        run_op("ldi_timeout", OP_LDI, 16'h0302, 16'h0, 3'd4, 255, d);
        run_op("sti_edge", OP_STI, 16'h0304, 16'h1357, 3'd1, int'(MAXW), d);
        run_op("ldr_edge", OP_LDR, 16'h0306, 16'h0, 3'd0, int'(MAXW) - 1, d);
    endtask

    task automatic test_non_mem();
        logic [3:0] ops [4];
        bit         vld [4];
        bit         bad;
        ops[0] = OP_ADD; vld[0] = 1'b1;
        ops[1] = OP_JMP; vld[1] = 1'b1;
        ops[2] = OP_LDR; vld[2] = 1'b0;
        ops[3] = OP_STI; vld[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bad = 1'b0;
            @(negedge clk);
            mem_valid_in = vld[k]; opcode_in = ops[k]; ea_in = 16'($urandom);
            #1;
            if (stall_out) bad = 1'b1;
            repeat (4) begin
                @(posedge clk); #1;
                if (stall_out || wb_valid || dcache_read || dcache_write) bad = 1'b1;
            end
            n_checks++;
            if (bad) begin n_errors++; $display("FAIL non_mem_%0d: op %b valid %0b got activity exp none", k, ops[k], vld[k]); end
        end
        mem_valid_in = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] d, ea;
        logic [3:0]  op;
        for (int i = 0; i < 32; i++)
            mem[16'h0100 + 16'(2 * i)] = 16'h0100 + 16'(2 * $urandom_range(0, 31)) + 16'($urandom_range(0, 1));
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: op = OP_LDR;
                1: op = OP_STR;
                2: op = OP_LDI;
                default: op = OP_STI;
            endcase
            ea = 16'h0100 + 16'(2 * $urandom_range(0, 31)) + 16'($urandom_range(0, 1));
            run_op($sformatf("rand_%0d", i), op, ea, 16'($urandom), 3'($urandom), $urandom_range(0, 5), d);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        mem[16'h0500] = 16'h1111;
        lat_cfg = 3;
        @(negedge clk);
        mem_valid_in = 1'b1; opcode_in = OP_LDR; ea_in = 16'h0500; dest_in = 3'd2;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (dcache_read !== 1'b1 || stall_out !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_pre: rd=%0b stall=%0b exp 1/1", dcache_read, stall_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dcache_read, dcache_write, stall_out, wb_valid, mem_err} !== 5'b0) begin
            n_errors++; $display("FAIL reset_mid_async: rd=%0b wr=%0b stall=%0b wb=%0b err=%0b exp 0",
                                 dcache_read, dcache_write, stall_out, wb_valid, mem_err);
        end
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wb_valid || stall_out || dcache_read) bad = 1'b1;
        end
        @(negedge clk);
        mem_valid_in = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb_valid || stall_out || dcache_read || dcache_write) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL reset_mid_after: activity or wb_valid seen, exp none"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_off();
        test_watchdog();
        test_non_mem();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
